d5m_frame_receiver: RTL
=======================

Name: d5m_frame_receiver

Overview:
Receiver end of the D5M camera interface. Accepts the raw fval/lval/pixel stream from the D5M model or sensor front end, frame-locks to it, and emits a registered rgb_channel-style stream with valid, lvalid, fvalid, sof, eof, x and y. It also checks line and frame geometry against configured values. It sits between the camera input and the VFP pixel pipeline.

Parameters:
DATA_WIDTH, 24, pixel word width on iData and oRgb.
IMG_WIDTH, 100, expected valid pixels per line.
IMG_HEIGHT, 5, expected lines per frame.
COORD_WIDTH, 12, width of the x/y counters.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
iFval  in  1  camera frame valid
iLval  in  1  camera line valid; pixel qualifier
iData  in  DATA_WIDTH  camera pixel
oValid  out  1  output pixel valid
oLvalid  out  1  registered line valid, gated by lock
oFvalid  out  1  registered frame valid, gated by lock
oSof  out  1  pulse with first pixel of a frame
oEof  out  1  pulse on the cycle after fval falls
oRgb  out  DATA_WIDTH  registered pixel
oX  out  COORD_WIDTH  pixel column of oRgb
oY  out  COORD_WIDTH  line row of oRgb
oFrameCnt  out  16  completed frames, wraps at 0xFFFF
oErr  out  3  sticky {coord_ovf, lval_outside_fval, geometry_err}
iErrClr  in  1  clears oErr

Behaviour:
- Reset is synchronous on rst=1.
  - All outputs go to 0.
  - FSM goes to SYNC.
  - Counters are cleared.
  - Reset overrides every other event, including mid-frame.
- Latency: one clock from iData/iLval to oRgb/oValid. All outputs are registered.
- FSM states:
  - SYNC: wait for iFval=0. This discards any partial frame seen after reset. Then go to IDLE.
  - IDLE: on iFval 0→1 go to FRAME; y=0.
  - FRAME: on iLval 0→1 go to LINE; x=0.
  - LINE: oValid=1 every cycle iLval=1. x increments after each pixel.
  - LINE, on iLval 1→0: if x≠IMG_WIDTH, set geometry_err. Increment y and return to FRAME.
  - FRAME/LINE, on iFval 1→0 (with iLval=0): go to IDLE; pulse oEof for one cycle. If lines≠IMG_HEIGHT, set geometry_err. Increment oFrameCnt.
- oSof = first oValid pixel with y=0 and x=0, one cycle only.
- Simultaneous fval and lval fall: treat the line end first, then the frame end. oEof fires in the same cycle as the line-length check.
- iLval=1 while iFval=0 (in IDLE or SYNC): set lval_outside_fval; pixel dropped, oValid=0.
- x or y reaching 2^COORD_WIDTH-1: counter saturates and coord_ovf is set. Pixels still pass.
- oErr bits are sticky until iErrClr. If iErrClr and a new error occur in the same cycle, the new error wins.
- iFval rising while the FSM is in FRAME (i.e. a fall was missed): not possible by edge definition. An fval glitch shorter than one clock is not supported.

Optional Feature:
Macro D5M_RX_BAYER_PACK_EN.
- Defined: iData[11:0] is a 12-bit Bayer sample. oRgb = {iData[11:4], iData[11:4], iData[11:4]} (grey replicate, 8 bits per channel), DATA_WIDTH fixed at 24. Latency is unchanged.
- Undefined: oRgb = iData unchanged.

Decomposition:
- generic_pack gains:
  - parameters d5m_rx_img_width and d5m_rx_img_height (defaults 100 and 5);
  - the err bit index constants.
- The existing rgb_channel struct is the bench-side output view: valid, lvalid, fvalid, eof, sof, rgb, x, y map 1:1.
- One sub-module, d5m_rx_geom_check, holds the x/y counters, saturation logic, geometry compare and sticky error register. The top holds the FSM and output registers.

Test Plan:
- Nominal frame: fval high; 5 lines of 100 pixels each, 10-cycle lval gaps; pixel = incrementing 24'h000001.
  - Expect 500 oValid.
  - oSof with x=0,y=0, rgb=1, one cycle after the first lval pixel.
  - Last pixel x=99,y=4; oEof one cycle after fval falls.
  - oFrameCnt=1; oErr=0.
- Short line: line 2 carries 99 pixels → geometry_err=1 at that lval fall. Remaining lines still output with correct y. iErrClr → oErr=0.
- Reset mid-frame: assert rst during line 3 for 1 cycle.
  - Outputs go to 0.
  - No oValid until fval has dropped and risen again.
  - The next full frame gives oSof and oFrameCnt=1.
- Lval outside fval: pulse iLval for 4 cycles with iFval=0 → oValid stays 0; oErr[1]=1.
- Frame height: 6 lines of 100 → geometry_err set at fval fall; oEof still pulses; oFrameCnt increments.
- Bayer pack (macro on): iData=12'hAB5 → oRgb=24'hABABAB one cycle later.

Source files
------------

// File: rtl/d5m_frame_receiver_pkg.sv
// Shared types and constants for the D5M frame receiver: FSM states, error bit
// positions, default frame geometry and the bench-side rgb_channel output view.
package d5m_frame_receiver_pkg;

  localparam int D5M_RX_IMG_WIDTH  = 100;
  localparam int D5M_RX_IMG_HEIGHT = 5;

  localparam int ERR_W        = 3;
  localparam int ERR_GEOM_BIT = 0;
  localparam int ERR_LVAL_BIT = 1;
  localparam int ERR_OVF_BIT  = 2;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_IDLE,
    ST_FRAME,
    ST_LINE
  } rx_state_e;

  typedef struct packed {
    logic        valid;
    logic        lvalid;
    logic        fvalid;
    logic        eof;
    logic        sof;
    logic [23:0] rgb;
    logic [11:0] x;
    logic [11:0] y;
  } rgb_channel_t;

endpackage

// File: rtl/d5m_rx_geom_check.sv
// Column/row counters with saturation, line/frame geometry compare and the
// sticky error register of the D5M receiver.
module d5m_rx_geom_check
  import d5m_frame_receiver_pkg::*;
#(
  parameter int IMG_WIDTH   = D5M_RX_IMG_WIDTH,
  parameter int IMG_HEIGHT  = D5M_RX_IMG_HEIGHT,
  parameter int COORD_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start_i,
  input  logic                   line_start_i,
  input  logic                   pix_i,
  input  logic                   line_end_i,
  input  logic                   frame_end_i,
  input  logic                   lval_err_i,
  input  logic                   err_clr_i,
  output logic [COORD_WIDTH-1:0] pix_x_o,
  output logic [COORD_WIDTH-1:0] pix_y_o,
  output logic [ERR_W-1:0]       err_o
);

  localparam logic [COORD_WIDTH-1:0] COORD_MAX = '1;
  localparam logic [COORD_WIDTH-1:0] WIDTH_C   = COORD_WIDTH'(IMG_WIDTH);
  localparam logic [COORD_WIDTH-1:0] HEIGHT_C  = COORD_WIDTH'(IMG_HEIGHT);

  logic [COORD_WIDTH-1:0] col_q, col_d;
  logic [COORD_WIDTH-1:0] row_q, row_d;
  logic [COORD_WIDTH-1:0] lines;
  logic [ERR_W-1:0]       err_q, err_d, new_err;

  function automatic logic [COORD_WIDTH-1:0] sat_inc(input logic [COORD_WIDTH-1:0] v);
    return (v == COORD_MAX) ? v : v + COORD_WIDTH'(1);
  endfunction

  // col_q = pixels already seen in the current line, row_q = lines completed.
  always_comb begin
    pix_x_o = line_start_i ? '0 : col_q;
    pix_y_o = frame_start_i ? '0 : row_q;
    lines   = line_end_i ? sat_inc(row_q) : row_q;
    col_d   = col_q;
    row_d   = row_q;
    new_err = '0;
    if (frame_start_i) row_d = '0;
    if (pix_i) begin
      col_d = sat_inc(pix_x_o);
      if (pix_x_o == COORD_MAX || pix_y_o == COORD_MAX) new_err[ERR_OVF_BIT] = 1'b1;
    end
    if (line_end_i) begin
      row_d = sat_inc(row_q);
      if (col_q != WIDTH_C) new_err[ERR_GEOM_BIT] = 1'b1;
    end
    // A line ending together with the frame is already included in lines.
    if (frame_end_i && lines != HEIGHT_C) new_err[ERR_GEOM_BIT] = 1'b1;
    if (lval_err_i) new_err[ERR_LVAL_BIT] = 1'b1;
    err_d = (err_clr_i ? '0 : err_q) | new_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      err_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/d5m_frame_receiver.sv
// D5M camera receiver: frame-locks to fval/lval and emits a registered pixel
// stream with coordinates. Optional grey Bayer packing via D5M_RX_BAYER_PACK_EN.
module d5m_frame_receiver
  import d5m_frame_receiver_pkg::*;
#(
  parameter int DATA_WIDTH  = 24,
  parameter int IMG_WIDTH   = D5M_RX_IMG_WIDTH,
  parameter int IMG_HEIGHT  = D5M_RX_IMG_HEIGHT,
  parameter int COORD_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iFval,
  input  logic                   iLval,
  input  logic [DATA_WIDTH-1:0]  iData,
  output logic                   oValid,
  output logic                   oLvalid,
  output logic                   oFvalid,
  output logic                   oSof,
  output logic                   oEof,
  output logic [DATA_WIDTH-1:0]  oRgb,
  output logic [COORD_WIDTH-1:0] oX,
  output logic [COORD_WIDTH-1:0] oY,
  output logic [15:0]            oFrameCnt,
  output logic [ERR_W-1:0]       oErr,
  input  logic                   iErrClr
);

  rx_state_e state_q, state_d;

  logic                   in_frame, pix, lval_err;
  logic                   frame_start, line_start, line_end, frame_end;
  logic [COORD_WIDTH-1:0] pix_x, pix_y;
  logic [DATA_WIDTH-1:0]  rgb_in;

  logic                   valid_q, lvalid_q, fvalid_q, sof_q, eof_q;
  logic [DATA_WIDTH-1:0]  rgb_q;
  logic [COORD_WIDTH-1:0] x_q, y_q;
  logic [15:0]            frame_cnt_q;

`ifdef D5M_RX_BAYER_PACK_EN
  assign rgb_in = DATA_WIDTH'({3{iData[11:4]}});
`else
  assign rgb_in = iData;
`endif

  // States encode the previous fval/lval levels, so edges reduce to levels here.
  always_comb begin
    in_frame    = (state_q != ST_SYNC) && iFval;
    pix         = in_frame && iLval;
    lval_err    = iLval && !iFval && (state_q == ST_SYNC || state_q == ST_IDLE);
    frame_start = (state_q == ST_IDLE) && iFval;
    line_start  = pix && (state_q != ST_LINE);
    line_end    = (state_q == ST_LINE) && !(iLval && iFval);
    frame_end   = (state_q == ST_FRAME || state_q == ST_LINE) && !iFval;
    state_d     = state_q;
    case (state_q)
      ST_SYNC:  if (!iFval) state_d = ST_IDLE;
      ST_IDLE:  if (iFval) state_d = iLval ? ST_LINE : ST_FRAME;
      ST_FRAME: begin
        if (!iFval)     state_d = ST_IDLE;
        else if (iLval) state_d = ST_LINE;
      end
      ST_LINE: begin
        if (!iFval)      state_d = ST_IDLE;
        else if (!iLval) state_d = ST_FRAME;
      end
      default: state_d = ST_SYNC;
    endcase
  end

  d5m_rx_geom_check #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .COORD_WIDTH(COORD_WIDTH)
  ) u_geom (
    .clk          (clk),
    .rst          (rst),
    .frame_start_i(frame_start),
    .line_start_i (line_start),
    .pix_i        (pix),
    .line_end_i   (line_end),
    .frame_end_i  (frame_end),
    .lval_err_i   (lval_err),
    .err_clr_i    (iErrClr),
    .pix_x_o      (pix_x),
    .pix_y_o      (pix_y),
    .err_o        (oErr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SYNC;
      valid_q     <= 1'b0;
      lvalid_q    <= 1'b0;
      fvalid_q    <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      rgb_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= pix;
      lvalid_q <= pix;
      fvalid_q <= in_frame;
      sof_q    <= pix && (pix_x == '0) && (pix_y == '0);
      eof_q    <= frame_end;
      if (pix) begin
        rgb_q <= rgb_in;
        x_q   <= pix_x;
        y_q   <= pix_y;
      end
      if (frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign oValid    = valid_q;
  assign oLvalid   = lvalid_q;
  assign oFvalid   = fvalid_q;
  assign oSof      = sof_q;
  assign oEof      = eof_q;
  assign oRgb      = rgb_q;
  assign oX        = x_q;
  assign oY        = y_q;
  assign oFrameCnt = frame_cnt_q;

endmodule
